// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// Module   : pc_sequencer_pkg
// Purpose  : Shared defaults, state encoding and next-PC select codes for the
//            program-counter sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

  localparam int unsigned c_PC_W        = 16;
  localparam int unsigned c_PC_STEP     = 2;
  localparam logic [15:0] c_RESET_PC    = 16'h0000;
  localparam logic [15:0] c_TRAP_VECTOR = 16'h0010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } seqState_t;

  typedef enum logic [1:0] {
    SEL_HOLD     = 2'd0,
    SEL_INC      = 2'd1,
    SEL_REDIRECT = 2'd2,
    SEL_TRAP     = 2'd3
  } pcSel_t;

endpackage : pc_sequencer_pkg

`default_nettype wire

// File: rtl/pc_sequencer_pc_next_sel.sv
// ============================================================================
// Module   : pc_next_sel
// Purpose  : Combinational next-PC mux: hold / sequential step / redirect
//            target / trap vector, plus the wrapping sequential PC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_sel
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned     PC_W        = c_PC_W,
  parameter int unsigned     PC_STEP     = c_PC_STEP,
  parameter logic [PC_W-1:0] TRAP_VECTOR = PC_W'(c_TRAP_VECTOR)
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] redirectTarget,
  input  pcSel_t          sel,
  output logic [PC_W-1:0] pcNext,
  output logic [PC_W-1:0] pcInc
);

  // Modular add: the step silently wraps past the top of the address space.
  always_comb begin
    pcInc = pc + PC_W'(PC_STEP);
  end

  always_comb begin
    pcNext = pc;
    case (sel)
      SEL_HOLD:     pcNext = pc;
      SEL_INC:      pcNext = pcInc;
      SEL_REDIRECT: pcNext = redirectTarget;
      SEL_TRAP:     pcNext = TRAP_VECTOR;
      default:      pcNext = pc;
    endcase
  end

endmodule : pc_next_sel

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Owns the program counter and runs the req/ack instruction fetch
//            handshake with redirect, stall and halt control.
//            Optional build macro PC_ALIGN_CHECK_EN: odd redirect targets trap
//            to TRAP_VECTOR and pulse align_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned     PC_W        = c_PC_W,
  parameter logic [PC_W-1:0] RESET_PC    = PC_W'(c_RESET_PC),
  parameter int unsigned     PC_STEP     = c_PC_STEP,
  parameter logic [PC_W-1:0] TRAP_VECTOR = PC_W'(c_TRAP_VECTOR)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next_seq,
  output logic            instr_valid,
  output logic            halted
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic            align_err
`endif
);

  seqState_t       r_state;
  seqState_t       w_nextState;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pcNext;
  logic [PC_W-1:0] w_pcInc;
  pcSel_t          w_pcSel;
  logic            r_instrValid;
  logic            w_instrValidNext;
  logic            w_takeRedirect;
  logic            w_redirectOdd;
  logic            w_alignErrNext;

`ifdef PC_ALIGN_CHECK_EN
  assign w_redirectOdd = redirect_target[0];
`else
  assign w_redirectOdd = 1'b0;
`endif

  assign w_takeRedirect = redirect_valid && (r_state != HALTED);

  always_comb begin
    w_nextState      = r_state;
    w_pcSel          = SEL_HOLD;
    w_instrValidNext = 1'b0;
    w_alignErrNext   = 1'b0;

    case (r_state)
      IDLE: begin
        w_nextState = halt ? HALTED : FETCH;
      end
      FETCH: begin
        // Without an ack the request stays up, even under halt, so the
        // in-flight fetch is allowed to complete.
        if (imem_ack) begin
          w_pcSel          = SEL_INC;
          w_instrValidNext = 1'b1;
          w_nextState      = halt ? HALTED : (stall ? HOLD : FETCH);
        end
      end
      HOLD: begin
        w_nextState = halt ? HALTED : (stall ? HOLD : FETCH);
      end
      HALTED: begin
        w_nextState = HALTED;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    // Redirect overrides everything above; a coincident ack is discarded.
    if (w_takeRedirect) begin
      w_instrValidNext = 1'b0;
      w_nextState      = halt ? HALTED : FETCH;
      w_pcSel          = w_redirectOdd ? SEL_TRAP : SEL_REDIRECT;
      w_alignErrNext   = w_redirectOdd;
    end
  end

  pc_next_sel #(
    .PC_W        (PC_W),
    .PC_STEP     (PC_STEP),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_pcNextSel (
    .pc             (r_pc),
    .redirectTarget (redirect_target),
    .sel            (w_pcSel),
    .pcNext         (w_pcNext),
    .pcInc          (w_pcInc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_instrValid <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_pc         <= w_pcNext;
      r_instrValid <= w_instrValidNext;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic r_alignErr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alignErr <= 1'b0;
    end else begin
      r_alignErr <= w_alignErrNext;
    end
  end

  assign align_err = r_alignErr;
`else
  logic w_unusedAlign;
  assign w_unusedAlign = w_alignErrNext;
`endif

  assign imem_req    = (r_state == FETCH);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_next_seq = w_pcInc;
  assign instr_valid = r_instrValid;
  assign halted      = (r_state == HALTED);

endmodule : pc_sequencer

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer; accepted-fetch addresses
//            are scoreboarded against a queue of expected addresses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        halt;
  logic [15:0] pc;
  logic [15:0] pc_next_seq;
  logic        instr_valid;
  logic        halted;
`ifdef PC_ALIGN_CHECK_EN
  logic        align_err;
`endif

  int          nChecks    = 0;
  int          nFails     = 0;
  int          validCount = 0;
  bit          monEn      = 1'b0;
  logic [15:0] expFetch[$];

  pc_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .pc              (pc),
    .pc_next_seq     (pc_next_seq),
    .instr_valid     (instr_valid),
    .halted          (halted)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .align_err       (align_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scores the handshake about to be sampled, then advances to the next negedge.
  task automatic step();
    if (monEn && imem_req && imem_ack && !redirect_valid) begin
      checkEq("fetch_expected", 32'(expFetch.size() != 0), 32'd1);
      if (expFetch.size() != 0) begin
        checkEq("fetch_addr", 32'(imem_addr), 32'(expFetch.pop_front()));
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (monEn && instr_valid) validCount++;
  endtask

  initial begin
    rst_n           = 1'b0;
    imem_ack        = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 16'h0000;
    halt            = 1'b0;

    step();
    step();
    checkEq("rst_pc", 32'(pc), 32'h0000);
    checkEq("rst_req", 32'(imem_req), 32'd0);
    checkEq("rst_valid", 32'(instr_valid), 32'd0);
    checkEq("rst_halted", 32'(halted), 32'd0);

    // Free-running fetch with ack tied high.
    expFetch.push_back(16'h0000);
    expFetch.push_back(16'h0002);
    expFetch.push_back(16'h0004);
    expFetch.push_back(16'h0006);
    rst_n    = 1'b1;
    imem_ack = 1'b1;
    monEn    = 1'b1;
    checkEq("idle_req", 32'(imem_req), 32'd0);
    step();
    checkEq("first_req", 32'(imem_req), 32'd1);
    checkEq("first_addr", 32'(imem_addr), 32'h0000);
    checkEq("first_valid", 32'(instr_valid), 32'd0);
    step();
    checkEq("valid_cycle3", 32'(instr_valid), 32'd1);
    step();
    step();
    checkEq("pc_0006", 32'(pc), 32'h0006);

    // Ack with stall at 0006 -> HOLD for three cycles.
    stall = 1'b1;
    step();
    checkEq("hold_pc", 32'(pc), 32'h0008);
    checkEq("hold_req1", 32'(imem_req), 32'd0);
    checkEq("hold_valid", 32'(instr_valid), 32'd1);
    step();
    checkEq("hold_req2", 32'(imem_req), 32'd0);
    step();
    checkEq("hold_req3", 32'(imem_req), 32'd0);
    checkEq("hold_pc3", 32'(pc), 32'h0008);
    stall = 1'b0;
    expFetch.push_back(16'h0008);
    step();
    checkEq("resume_req", 32'(imem_req), 32'd1);
    checkEq("resume_addr", 32'(imem_addr), 32'h0008);
    checkEq("valid_count_a", 32'(validCount), 32'd4);
    step();
    checkEq("pc_000a", 32'(pc), 32'h000A);

    // Redirect coinciding with an ack at 000A.
    redirect_valid  = 1'b1;
    redirect_target = 16'h0040;
    step();
    checkEq("redir_no_valid", 32'(instr_valid), 32'd0);
    checkEq("redir_addr", 32'(imem_addr), 32'h0040);

    // Redirect to FFFC, then wrap through zero.
    redirect_target = 16'hFFFC;
    step();
    checkEq("wrap_start", 32'(pc), 32'hFFFC);
    redirect_valid = 1'b0;
    expFetch.push_back(16'hFFFC);
    expFetch.push_back(16'hFFFE);
    expFetch.push_back(16'h0000);
    expFetch.push_back(16'h0002);
    step();
    checkEq("wrap_fffe", 32'(imem_addr), 32'hFFFE);
    checkEq("wrap_nextseq", 32'(pc_next_seq), 32'h0000);
    step();
    checkEq("wrap_0000", 32'(imem_addr), 32'h0000);
    step();
    step();
    checkEq("wrap_0004", 32'(pc), 32'h0004);

    // Redirect to 0012, then halt with the ack withheld for two cycles.
    redirect_valid  = 1'b1;
    redirect_target = 16'h0012;
    step();
    checkEq("redir2_no_valid", 32'(instr_valid), 32'd0);
    redirect_valid = 1'b0;
    imem_ack       = 1'b0;
    halt           = 1'b1;
    step();
    checkEq("halt_wait_req1", 32'(imem_req), 32'd1);
    checkEq("halt_wait_addr1", 32'(imem_addr), 32'h0012);
    step();
    checkEq("halt_wait_req2", 32'(imem_req), 32'd1);
    checkEq("halt_wait_halted", 32'(halted), 32'd0);
    imem_ack = 1'b1;
    expFetch.push_back(16'h0012);
    step();
    checkEq("halted_flag", 32'(halted), 32'd1);
    checkEq("halted_pc", 32'(pc), 32'h0014);
    checkEq("halted_req", 32'(imem_req), 32'd0);
    checkEq("halted_valid", 32'(instr_valid), 32'd1);
    checkEq("valid_count_b", 32'(validCount), 32'd10);

    imem_ack        = 1'b0;
    halt            = 1'b0;
    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 16'h0100;
    step();
    checkEq("halted_ignore_pc", 32'(pc), 32'h0014);
    checkEq("halted_ignore_flag", 32'(halted), 32'd1);
    redirect_valid = 1'b0;
    stall          = 1'b0;

    // Asynchronous reset mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    checkEq("async_pc", 32'(pc), 32'h0000);
    checkEq("async_halted", 32'(halted), 32'd0);
    checkEq("sb_empty", 32'(expFetch.size()), 32'd0);

    // Odd redirect target straight out of IDLE.
    @(negedge clk);
    rst_n           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 16'h0031;
    step();
    redirect_valid = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    checkEq("align_pc", 32'(pc), 32'h0010);
    checkEq("align_err_hi", 32'(align_err), 32'd1);
    step();
    checkEq("align_err_lo", 32'(align_err), 32'd0);
`else
    checkEq("odd_pc", 32'(pc), 32'h0031);
    checkEq("odd_req", 32'(imem_req), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule : tb_pc_sequencer

`default_nettype wire
